// File: rtl/telemetry_tx_pkg.sv
// Shared constants and state encodings for the telemetry UART transmitter.
package telemetry_tx_pkg;

  localparam logic [7:0] TLM_HEADER    = 8'hA5;
  localparam int         TLM_FRAME_LEN = 5;

  typedef enum logic [1:0] {
    FR_IDLE = 2'd0,
    FR_LOAD = 2'd1,
    FR_SEND = 2'd2
  } framer_state_t;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_START = 2'd1,
    SER_DATA  = 2'd2,
    SER_STOP  = 2'd3
  } ser_state_t;

  function automatic logic [7:0] tlm_checksum(input logic [7:0] a,
                                              input logic [7:0] b,
                                              input logic [7:0] c);
    return a ^ b ^ c;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A start request at the end of a stop bit chains the next
// byte with no idle time, so byte_done is combinational on the final stop cycle.
module uart_tx_byte
  import telemetry_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1667
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       Tx,
  output logic       byte_done,
  output logic       busy
);

  localparam int                CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  ser_state_t       state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             bit_end;

  assign bit_end   = (baud_cnt == CNT_LAST);
  assign byte_done = (state == SER_STOP) && bit_end;
  assign busy      = (state != SER_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SER_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      Tx       <= 1'b1;
    end else begin
      case (state)
        SER_IDLE: begin
          if (start) begin
            shreg    <= data;
            baud_cnt <= '0;
            Tx       <= 1'b0;
            state    <= SER_START;
          end
        end
        SER_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            Tx       <= shreg[0];
            state    <= SER_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        SER_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              Tx    <= 1'b1;
              state <= SER_STOP;
            end else begin
              // shreg[0] is on the line; shreg[1] is the next bit out
              bit_cnt <= bit_cnt + 3'd1;
              Tx      <= shreg[1];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        SER_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (start) begin
              shreg <= data;
              Tx    <= 1'b0;
              state <= SER_START;
            end else begin
              state <= SER_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= SER_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/telemetry_tx.sv
// Robot telemetry transmitter: periodic/on-demand 5-byte status frame over UART,
// payload snapshotted when the frame is accepted.
module telemetry_tx
  import telemetry_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 1667,
  parameter int REPORT_CYCLES = 1600000
) (
  input  logic       WF_CLK,
  input  logic       WF_BUTTON,
  input  logic       enable,
  input  logic       send,
  input  logic [5:0] bump,
  input  logic [7:0] left_spd,
  input  logic [7:0] right_spd,
  output logic       Tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int               RPT_W    = (REPORT_CYCLES > 1) ? $clog2(REPORT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPORT_CYCLES - 1);
  localparam logic [2:0]       IDX_END  = 3'(TLM_FRAME_LEN);

  logic [RPT_W-1:0] rpt_cnt;
  logic             tick;
  logic             trigger;

  framer_state_t    fr_state;
  logic             pending;
  logic [2:0]       load_idx;
  logic [7:0]       snap_b1;
  logic [7:0]       snap_b2;
  logic [7:0]       snap_b3;
  logic [7:0]       snap_b4;

  logic             ser_start;
  logic [7:0]       ser_data;
  logic             ser_byte_done;
  logic             ser_busy;
  logic             last_done;

  assign tick    = enable && (rpt_cnt == RPT_LAST);
  assign trigger = tick || send;

  always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
    if (!WF_BUTTON) begin
      rpt_cnt <= '0;
    end else if (!enable || tick) begin
      rpt_cnt <= '0;
    end else begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end
  end

  // load_idx names the next byte to hand over; it reaches IDX_END once the
  // checksum byte has been accepted, so the following byte_done ends the frame.
  assign ser_start = (fr_state == FR_SEND) && (load_idx < IDX_END) &&
                     (!ser_busy || ser_byte_done);
  assign last_done = (fr_state == FR_SEND) && ser_byte_done && (load_idx == IDX_END);

  always_comb begin
    ser_data = TLM_HEADER;
    case (load_idx)
      3'd1:    ser_data = snap_b1;
      3'd2:    ser_data = snap_b2;
      3'd3:    ser_data = snap_b3;
      3'd4:    ser_data = snap_b4;
      default: ser_data = TLM_HEADER;
    endcase
  end

  always_ff @(posedge WF_CLK or negedge WF_BUTTON) begin
    if (!WF_BUTTON) begin
      fr_state   <= FR_IDLE;
      pending    <= 1'b0;
      load_idx   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (fr_state)
        FR_IDLE: begin
          if (trigger || pending) begin
            fr_state <= FR_LOAD;
            busy     <= 1'b1;
            pending  <= 1'b0;
          end
        end
        FR_LOAD: begin
          fr_state <= FR_SEND;
          load_idx <= '0;
          if (trigger) pending <= 1'b1;
        end
        FR_SEND: begin
          if (ser_start) load_idx <= load_idx + 3'd1;
          if (last_done) begin
            frame_done <= 1'b1;
            pending    <= 1'b0;
            // a queued request rolls straight into the next frame
            if (pending || trigger) begin
              fr_state <= FR_LOAD;
            end else begin
              fr_state <= FR_IDLE;
              busy     <= 1'b0;
            end
          end else if (trigger) begin
            pending <= 1'b1;
          end
        end
        default: fr_state <= FR_IDLE;
      endcase
    end
  end

  always_ff @(posedge WF_CLK) begin
    if (fr_state == FR_LOAD) begin
      snap_b1 <= {2'b00, bump};
      snap_b2 <= left_spd;
      snap_b3 <= right_spd;
      snap_b4 <= tlm_checksum({2'b00, bump}, left_spd, right_spd);
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk      (WF_CLK),
    .rst_n    (WF_BUTTON),
    .start    (ser_start),
    .data     (ser_data),
    .Tx       (Tx),
    .byte_done(ser_byte_done),
    .busy     (ser_busy)
  );

endmodule

// File: doc/telemetry_tx.md
Name: telemetry_tx

Overview:
Bluetooth UART transmitter for robot telemetry. It is the Tx counterpart of the Rx command receiver, and its output drives the Tx line mapped to ir_snsrch1.
- Sends a fixed 5-byte status frame (header, bumpers, left/right speed, checksum).
- A frame is sent periodically, or on demand via a strobe.
- Payload is snapshotted at frame start, so mid-frame input changes never corrupt a frame.

Parameters:
CLKS_PER_BIT, 1667, WF_CLK cycles per UART bit (16 MHz / 9600 baud).
REPORT_CYCLES, 1600000, period of the automatic report tick in WF_CLK cycles (100 ms).

Ports:
WF_CLK  input  1  system clock, rising-edge.
WF_BUTTON  input  1  reset, asynchronous, active-low.
enable  input  1  1 = periodic reporting on; 0 = report timer held at 0.
send  input  1  single-cycle strobe requesting one frame.
bump  input  6  bumper switch levels {bump5..bump0}.
left_spd  input  8  left wheel measured speed.
right_spd  input  8  right wheel measured speed.
Tx  output  1  UART line; idle high, 8N1, LSB first.
busy  output  1  high from trigger acceptance until the last stop bit completes.
frame_done  output  1  one-cycle pulse at the end of the last stop bit.

Behaviour:
- Reset (async, WF_BUTTON=0):
  - Tx=1, busy=0, frame_done=0.
  - Report counter, pending flag, byte index, bit counter and baud counter all cleared.
  - Takes effect immediately, including mid-bit; any frame in progress is abandoned, not resumed.
- Report timer:
  - While enable=1, counts 0..REPORT_CYCLES-1 and raises tick for one cycle on wrap.
  - While enable=0, held at 0 with no tick.
- Trigger = tick OR send.
  - Trigger while idle: accepted.
  - Trigger while busy: sets a 1-deep pending flag. Further triggers while pending are dropped.
  - On frame end with pending=1: the next frame starts with no idle gap beyond the normal start, and pending clears.
- Framer FSM: IDLE -> LOAD -> SEND -> IDLE.
  - IDLE: wait for trigger or pending.
  - LOAD: one cycle. Snapshot b0=8'hA5, b1={2'b00,bump}, b2=left_spd, b3=right_spd, b4=b1^b2^b3. Byte index set to 0. busy rises on the edge entering LOAD.
  - SEND: hand byte[index] to the serializer. On each byte-done, index++. After index 4 completes, pulse frame_done and return to IDLE (busy drops the same edge).
- Serializer FSM: IDLE -> START -> DATA -> STOP.
  - START drives 0; DATA drives bits 0..7; STOP drives 1.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - Consecutive bytes are back-to-back: the stop bit of byte k is followed directly by the start bit of byte k+1.
- Latency: trigger sampled at edge N; Tx falls at edge N+2.
- Frame duration: exactly 50*CLKS_PER_BIT cycles from Tx falling to frame_done.
- Simultaneous send and tick count as one trigger.
- enable falling mid-frame does not abort the frame.
- Tx is a registered output; it must not glitch.

Decomposition:
- Shared include/package telemetry_defs:
  - TLM_HEADER=8'hA5, TLM_FRAME_LEN=5.
  - Framer state encodings.
  - Serializer state encodings.
- Natural sub-module: uart_tx_byte.
  - Ports: clk, rst_n, start, data[7:0], Tx, byte_done, busy.
  - Owns the baud counter and bit shifting.
  - The top owns the report timer, pending flag, snapshot and framer.
- Target size: about 250 lines of RTL total.

Test Plan:
(Bench uses CLKS_PER_BIT=4 and REPORT_CYCLES=400.)
1. Manual send: enable=0, bump=6'h3F, left_spd=8'h12, right_spd=8'h34, one-cycle send pulse.
   - Tx falls 2 cycles later.
   - Decoded bytes are A5,3F,12,34,19.
   - frame_done pulses exactly 200 cycles after Tx falls; busy=0 the same edge.
2. Snapshot: change left_spd to 8'hFF during byte 1.
   - Frame still carries 12 and checksum 19.
   - The next frame carries FF and checksum 3F^FF^34=8'hF4.
3. Pending: three send pulses while busy.
   - Exactly two frames are produced, back-to-back.
   - No third frame.
4. Periodic mode: enable=1, send=0 for 1300 cycles.
   - Frames start every 400 cycles.
   - Tx stays high between frames.
   - enable=0 mid-frame: the current frame completes and no further frames start.
5. Reset mid-byte: assert WF_BUTTON=0 during DATA of byte 2.
   - Tx=1 and busy=0 immediately, asynchronously.
   - After release, Tx stays idle until the next trigger; pending is cleared.
6. Bit timing: every Tx level lasts a multiple of 4 cycles.
   - Start bit = 4 cycles; stop bit = 4 cycles.
   - No idle cycles between bytes within a frame.
